// File: rtl/scan_sched.sv
// scan_sched: time-multiplexed keypad scanner and display sequencer.
//
// One scan tick every TICK_DIV clocks advances a shared strobe (sel) over
// keypad rows 0..3 and seven-segment digits 0..5. The keypad column sampled
// on a tick belongs to the row strobed just before that tick. Accepted keys
// (after DEB_CNT matching samples) are shifted into a six-digit BCD buffer.
// A separate LED-matrix row walker produces character-ROM addresses for the
// newest digit.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   column      keypad column sense, active low (3'b111 = no key)
//   sel         shared row/digit strobe (0..5)
//   digit       BCD value of the digit addressed by sel (4'hF = blank)
//   key_valid   one-cycle pulse per accepted key
//   key_code    code of the last accepted key
//   buf_out     six-digit entry buffer, newest digit in [3:0]
//   row         one-hot LED-matrix row enable
//   glyph_addr  character-ROM address for the current matrix row
module scan_sched #(
  parameter int TICK_DIV = 8192,
  parameter int DEB_CNT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  column,
  output logic [2:0]  sel,
  output logic [3:0]  digit,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [23:0] buf_out,
  output logic [7:0]  row,
  output logic [7:0]  glyph_addr
);

  localparam logic [16:0] TICK_LAST = 17'(TICK_DIV - 1);
  localparam logic [3:0]  DEB_LAST  = 4'(DEB_CNT);

  typedef enum logic [1:0] {IDLE, DEB, HELD, REL} state_t;

  state_t      state, state_nxt;
  logic [16:0] tick_cnt;
  logic        tick;
  logic        press_valid;
  logic [3:0]  press_code;
  logic [1:0]  krow;
  logic [3:0]  kcode;
  logic [3:0]  cnt;
  logic [3:0]  cnt_inc;
  logic        krow_sample;
  logic        same_code;
  logic        capture;
  logic        cnt_load1;
  logic        cnt_step;
  logic        accept;
  logic [23:0] buf_nxt;
  logic [2:0]  row_idx;
  logic [2:0]  row_idx_nxt;

  // Scan tick divider
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 17'd1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Shared strobe walks 0..5
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel <= 3'd0;
    end else if (tick) begin
      sel <= (sel == 3'd5) ? 3'd0 : sel + 3'd1;
    end
  end

  // Keypad decode; anything outside the table, including any sample taken
  // while a display digit is strobed, is treated as no key
  always_comb begin
    press_valid = 1'b1;
    press_code  = 4'hF;
    case ({sel, column})
      {3'd0, 3'b011}: press_code = 4'd1;
      {3'd0, 3'b101}: press_code = 4'd2;
      {3'd0, 3'b110}: press_code = 4'd3;
      {3'd1, 3'b011}: press_code = 4'd4;
      {3'd1, 3'b101}: press_code = 4'd5;
      {3'd1, 3'b110}: press_code = 4'd6;
      {3'd2, 3'b011}: press_code = 4'd7;
      {3'd2, 3'b101}: press_code = 4'd8;
      {3'd2, 3'b110}: press_code = 4'd9;
      {3'd3, 3'b101}: press_code = 4'd0;
      default:        press_valid = 1'b0;
    endcase
  end

  // Once a key is being tracked only samples of its own row count
  assign krow_sample = tick && (sel == {1'b0, krow});
  assign same_code   = press_valid && (press_code == kcode);
  assign cnt_inc     = cnt + 4'd1;

  // Key FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Key FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (tick && press_valid) state_nxt = DEB;
      end
      DEB: begin
        if (krow_sample) begin
          if (!same_code)                state_nxt = IDLE;
          else if (cnt_inc == DEB_LAST)  state_nxt = HELD;
        end
      end
      HELD: begin
        if (krow_sample && !same_code) state_nxt = REL;
      end
      REL: begin
        if (krow_sample) begin
          if (same_code)                 state_nxt = HELD;
          else if (cnt_inc == DEB_LAST)  state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Key FSM datapath controls
  always_comb begin
    capture   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_step  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        capture   = tick && press_valid;
        cnt_load1 = tick && press_valid;
      end
      DEB: begin
        cnt_step = krow_sample && same_code;
        accept   = krow_sample && same_code && (cnt_inc == DEB_LAST);
      end
      HELD: begin
        cnt_load1 = krow_sample && !same_code;
      end
      REL: begin
        cnt_step = krow_sample && !same_code;
      end
      default: begin
        capture = 1'b0;
      end
    endcase
  end

  assign buf_nxt = accept ? {buf_out[19:0], kcode} : buf_out;

  // Key capture, debounce counter and entry buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      krow      <= 2'd0;
      kcode     <= 4'hF;
      cnt       <= 4'd0;
      key_valid <= 1'b0;
      key_code  <= 4'hF;
      buf_out   <= 24'hFFFFFF;
    end else begin
      key_valid <= accept;
      buf_out   <= buf_nxt;
      if (capture) begin
        krow  <= sel[1:0];
        kcode <= press_code;
      end
      if (cnt_load1) begin
        cnt <= 4'd1;
      end else if (cnt_step) begin
        cnt <= cnt_inc;
      end
      if (accept) begin
        key_code <= kcode;
      end
    end
  end

  // Digit mux, most significant buffer digit on sel 0
  always_comb begin
    case (sel)
      3'd0:    digit = buf_out[23:20];
      3'd1:    digit = buf_out[19:16];
      3'd2:    digit = buf_out[15:12];
      3'd3:    digit = buf_out[11:8];
      3'd4:    digit = buf_out[7:4];
      3'd5:    digit = buf_out[3:0];
      default: digit = 4'hF;
    endcase
  end

  // Glyph 0 of the ROM is blank; digit d lives at glyph d+1
  function automatic logic [7:0] glyph_of(input logic [3:0] d, input logic [2:0] idx);
    logic [7:0] base;
    if (d <= 4'd9) begin
      base = ({4'd0, d} + 8'd1) << 3;
    end else begin
      base = 8'd0;
    end
    return base + {5'd0, idx};
  endfunction

  assign row_idx_nxt = row_idx + 3'd1;

  // Matrix row walker; the address is built from the buffer value that is
  // current after this edge so row and glyph always agree
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row        <= 8'b1000_0000;
      row_idx    <= 3'd0;
      glyph_addr <= 8'd0;
    end else if (tick) begin
      row        <= {row[0], row[7:1]};
      row_idx    <= row_idx_nxt;
      glyph_addr <= glyph_of(buf_nxt[3:0], row_idx_nxt);
    end
  end

endmodule

// File: tb/tb_scan_sched.sv
// tb_scan_sched: directed self-checking bench for scan_sched with
// TICK_DIV=4 and DEB_CNT=3. Column stimulus is applied only while the
// targeted row is strobed, so each call to drive_samples produces exactly
// one sample per requested repetition on that row.
module tb_scan_sched;

  logic        clk;
  logic        reset;
  logic [2:0]  column;
  logic [2:0]  sel;
  logic [3:0]  digit;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [23:0] buf_out;
  logic [7:0]  row;
  logic [7:0]  glyph_addr;

  int checks      = 0;
  int errors      = 0;
  int pulse_count = 0;

  scan_sched #(.TICK_DIV(4), .DEB_CNT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .column     (column),
    .sel        (sel),
    .digit      (digit),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .buf_out    (buf_out),
    .row        (row),
    .glyph_addr (glyph_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent tally of accepted-key pulses
  always @(negedge clk) begin
    if (key_valid === 1'b1) pulse_count <= pulse_count + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic wait_sel(input logic [2:0] s);
    int w = 0;
    while (sel !== s && w < 64) begin
      @(negedge clk);
      w++;
    end
    check_output("wait_sel", 32'(w < 64), 32'd1);
  endtask

  // Present col on row r for n consecutive samples of that row
  task automatic drive_samples(input logic [2:0] r, input logic [2:0] col, input int n);
    for (int s = 0; s < n; s++) begin
      int w = 0;
      wait_sel(r);
      column = col;
      while (sel === r && w < 16) begin
        @(negedge clk);
        w++;
      end
      check_output("wait_sample", 32'(w < 16), 32'd1);
      column = 3'b111;
    end
  endtask

  function automatic logic [2:0] key_row(input int k);
    return (k == 0) ? 3'd3 : 3'((k - 1) / 3);
  endfunction

  function automatic logic [2:0] key_col(input int k);
    if (k == 0) return 3'b101;
    case ((k - 1) % 3)
      0:       return 3'b011;
      1:       return 3'b101;
      default: return 3'b110;
    endcase
  endfunction

  function automatic int onehot_idx(input logic [7:0] r);
    for (int i = 0; i < 8; i++) begin
      if (r[7-i] && (r == (8'h80 >> i))) return i;
    end
    return 99;
  endfunction

  // Clean press and release of key k
  task automatic apply_stimulus(input int k);
    drive_samples(key_row(k), key_col(k), 3);
    check_output("press_valid", 32'(key_valid), 32'd1);
    check_output("press_code", 32'(key_code), 32'(k));
    drive_samples(key_row(k), 3'b111, 3);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_sel"},   32'(sel), 32'd0);
    check_output({tag, "_digit"}, 32'(digit), 32'hF);
    check_output({tag, "_kv"},    32'(key_valid), 32'd0);
    check_output({tag, "_kc"},    32'(key_code), 32'hF);
    check_output({tag, "_buf"},   32'(buf_out), 32'hFFFFFF);
    check_output({tag, "_row"},   32'(row), 32'h80);
    check_output({tag, "_glyph"}, 32'(glyph_addr), 32'd0);
  endtask

  initial begin
    int base;
    logic [7:0]  seen;
    logic [23:0] exp_buf;

    reset  = 1'b0;
    column = 3'b111;
    repeat (3) @(negedge clk);
    check_reset_state("reset");

    // First tick lands TICK_DIV clocks after release
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("first_tick_sel_before", 32'(sel), 32'd0);
    @(negedge clk);
    check_output("first_tick_sel", 32'(sel), 32'd1);
    check_output("first_tick_row", 32'(row), 32'h40);
    check_output("first_tick_glyph", 32'(glyph_addr), 32'd1);

    // Key 3 on row 0: single pulse, buffer and glyph stream
    drive_samples(3'd0, 3'b110, 3);
    check_output("k3_valid", 32'(key_valid), 32'd1);
    check_output("k3_code", 32'(key_code), 32'd3);
    check_output("k3_buf", 32'(buf_out), 32'hFFFFF3);
    @(negedge clk);
    check_output("k3_valid_drop", 32'(key_valid), 32'd0);
    seen = 8'h00;
    for (int t = 0; t < 8; t++) begin
      int idx;
      repeat (4) @(negedge clk);
      idx = onehot_idx(row);
      check_output("k3_glyph", 32'(glyph_addr), 32'(32 + idx));
      if (idx < 8) seen[idx] = 1'b1;
    end
    check_output("k3_glyph_rows", 32'(seen), 32'hFF);
    wait_sel(3'd5);
    check_output("k3_digit5", 32'(digit), 32'd3);
    drive_samples(3'd0, 3'b111, 3);
    check_output("k3_pulses", 32'(pulse_count), 32'd1);

    // Keys 1..7: overflow drops the oldest digits
    base = pulse_count;
    for (int k = 1; k <= 7; k++) apply_stimulus(k);
    check_output("seq_buf", 32'(buf_out), 32'h234567);
    check_output("seq_pulses", 32'(pulse_count - base), 32'd7);
    exp_buf = 24'h234567;
    for (int s = 0; s < 6; s++) begin
      wait_sel(3'(s));
      check_output("seq_digit", 32'(digit), 32'(exp_buf[23 - 4*s -: 4]));
    end

    // Bounce too short to be accepted
    base = pulse_count;
    drive_samples(3'd1, 3'b011, 2);
    drive_samples(3'd1, 3'b111, 1);
    repeat (8) @(negedge clk);
    check_output("short_pulses", 32'(pulse_count - base), 32'd0);
    check_output("short_buf", 32'(buf_out), 32'h234567);

    // Long hold of key 5, short release, then a real release and re-press
    base = pulse_count;
    drive_samples(3'd1, 3'b101, 20);
    check_output("hold_pulses", 32'(pulse_count - base), 32'd1);
    drive_samples(3'd1, 3'b111, 1);
    drive_samples(3'd1, 3'b101, 2);
    check_output("rebounce_pulses", 32'(pulse_count - base), 32'd1);
    drive_samples(3'd1, 3'b111, 3);
    drive_samples(3'd1, 3'b101, 3);
    check_output("repress_valid", 32'(key_valid), 32'd1);
    check_output("repress_buf_lo", 32'(buf_out[7:0]), 32'h55);
    check_output("repress_buf", 32'(buf_out), 32'h456755);
    drive_samples(3'd1, 3'b111, 3);
    check_output("repress_pulses", 32'(pulse_count - base), 32'd2);

    // Illegal patterns and display-slot samples never register
    base = pulse_count;
    drive_samples(3'd2, 3'b001, 3);
    drive_samples(3'd3, 3'b011, 3);
    drive_samples(3'd4, 3'b011, 3);
    drive_samples(3'd5, 3'b110, 3);
    repeat (8) @(negedge clk);
    check_output("illegal_pulses", 32'(pulse_count - base), 32'd0);
    check_output("illegal_buf", 32'(buf_out), 32'h456755);

    // Key 0 on row 3
    apply_stimulus(0);
    check_output("k0_buf", 32'(buf_out), 32'h567550);

    // Reset while a key is held with FFF123 in the buffer
    reset = 1'b0;
    #2;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(1);
    apply_stimulus(2);
    drive_samples(3'd0, 3'b110, 3);
    check_output("held_buf", 32'(buf_out), 32'hFFF123);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("held_reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    base = pulse_count;
    repeat (60) @(negedge clk);
    check_output("held_after_pulses", 32'(pulse_count - base), 32'd0);
    check_output("held_after_buf", 32'(buf_out), 32'hFFFFFF);

    // Reset in the middle of debounce
    drive_samples(3'd0, 3'b011, 2);
    reset = 1'b0;
    #1;
    check_reset_state("deb_reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    base = pulse_count;
    repeat (60) @(negedge clk);
    check_output("deb_after_pulses", 32'(pulse_count - base), 32'd0);
    check_output("deb_after_buf", 32'(buf_out), 32'hFFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
